iir_sos_seq: RTL
================

IIR_SOS_SEQ -- requirements
Module: iir_sos_seq

Interface
REQ-001 Parameter NSOS, default 6: number of second-order sections per channel.
REQ-002 Parameter NCH, default 2: number of channels (real, imag) sharing one MAC datapath.
REQ-003 Derived constants: NTAP=5 (b0,b1,b2,a1,a2); CAW=$clog2(NSOS*NTAP); SAW=$clog2(NCH*NSOS).
REQ-004 clk  input  1  sole clock, rising edge; one clock, reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 dv_in  input  1  one-cycle pulse: new sample present on all NCH channel inputs.
REQ-007 busy  output  1  high while a sample sweep is in progress (any state except IDLE).
REQ-008 ch  output  $clog2(NCH)  channel currently driving the datapath.
REQ-009 coeff_addr  output  CAW  coefficient ROM address = sec*NTAP + tap.
REQ-010 st_addr  output  SAW  delay-line RAM address = ch*NSOS + sec.
REQ-011 opsel  output  3  operand select = tap (0:x[n], 1:x[n-1], 2:x[n-2], 3:y[n-1], 4:y[n-2]).
REQ-012 mac_clr  output  1  clear accumulator before this product (tap 0).
REQ-013 mac_en  output  1  accumulate product this cycle.
REQ-014 wb_en  output  1  write section result and shift the delay line at st_addr.
REQ-015 dv_out  output  1  one-cycle pulse: all channel outputs valid.
REQ-016 overrun  output  1  sticky flag: dv_in arrived while busy.

Function
REQ-017 FSM states SHALL be IDLE, MAC, WB, DONE; all outputs are registered.
REQ-018 IDLE: dv_in=1 SHALL load ch=0, sec=0, tap=0 and transition to MAC; otherwise remain in IDLE.
REQ-019 MAC: mac_en=1; mac_clr=1 only when tap=0; tap increments each cycle; at tap=4 the next state is WB and tap resets to 0.
REQ-020 WB: wb_en=1 for exactly one cycle, mac_en=0.
REQ-021 WB exit: sec<NSOS-1 -> sec+1, MAC; sec=NSOS-1 and ch<NCH-1 -> sec=0, ch+1, MAC; sec=NSOS-1 and ch=NCH-1 -> DONE.
REQ-022 DONE: dv_out=1 for one cycle, then IDLE.
REQ-023 Section output feeds the next section's x[n]; the sequencer SHALL NOT reorder sections (sec ascending, ch ascending).
REQ-024 Latency: dv_out SHALL assert exactly 1+NCH*NSOS*(NTAP+1) cycles after the dv_in sampling edge (73 at defaults).
REQ-025 dv_in while busy (MAC, WB or DONE) SHALL be ignored, SHALL NOT perturb the sweep, and SHALL set overrun.
REQ-026 dv_in in the IDLE cycle directly after DONE SHALL be accepted normally (back-to-back period of 74 cycles at defaults).
REQ-027 Outside MAC, mac_en and mac_clr SHALL be 0; outside WB, wb_en SHALL be 0.
REQ-028 coeff_addr and st_addr SHALL never exceed NSOS*NTAP-1 and NCH*NSOS-1.

Reset
REQ-029 rst SHALL force state=IDLE, ch=0, sec=0, tap=0, busy=0, mac_en=0, mac_clr=0, wb_en=0, dv_out=0, overrun=0, coeff_addr=0, st_addr=0, opsel=0.
REQ-030 rst mid-sweep SHALL abort the sweep with no dv_out; the next dv_in starts a fresh sweep.
REQ-031 overrun SHALL clear only on rst.

Structure
REQ-032 Package iir_pkg SHALL hold the FSM state enum, NTAP, and opsel encoding constants.
REQ-033 The block SHALL be a single module with no sub-modules; counters and FSM are inline.

Verification
REQ-034 Single dv_in at defaults -> busy high 73 cycles, 60 mac_en cycles, 12 wb_en cycles, one dv_out 73 cycles later.
REQ-035 Address trace -> coeff_addr 0..29 in order per channel, st_addr 0..5 then 6..11, opsel cycling 0..4, mac_clr only at opsel=0.
REQ-036 dv_in pulsed at cycle 10 of a sweep -> trace identical to REQ-034, overrun=1 from next cycle, persists until rst.
REQ-037 dv_in on the cycle after dv_out -> second sweep accepted, overrun stays 0.
REQ-038 rst asserted at cycle 30 of a sweep -> all outputs at reset values next cycle, no dv_out; subsequent dv_in yields dv_out after 73 cycles.
REQ-039 NSOS=1, NCH=1 -> dv_out 7 cycles after dv_in, one wb_en pulse.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants for the biquad-cascade MAC sequencer: FSM encoding,
// taps per section and operand-select codes.
package iir_pkg;
    localparam int NTAP = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_X0 = 3'd0;
    localparam logic [2:0] OP_X1 = 3'd1;
    localparam logic [2:0] OP_X2 = 3'd2;
    localparam logic [2:0] OP_Y1 = 3'd3;
    localparam logic [2:0] OP_Y2 = 3'd4;
endpackage

// File: rtl/iir_sos_seq.sv
// Sequencer for a time-multiplexed cascade of second-order IIR sections.
// Walks every channel through every section, one MAC tap per cycle.
module iir_sos_seq
    import iir_pkg::*;
#(
    parameter int NSOS = 6,
    parameter int NCH  = 2,
    localparam int CAW = $clog2(NSOS*NTAP),
    localparam int SAW = (NCH*NSOS > 1) ? $clog2(NCH*NSOS) : 1,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           dv_in,
    output logic           busy,
    output logic [CHW-1:0] ch,
    output logic [CAW-1:0] coeff_addr,
    output logic [SAW-1:0] st_addr,
    output logic [2:0]     opsel,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           wb_en,
    output logic           dv_out,
    output logic           overrun
);
    localparam int SW = (NSOS > 1) ? $clog2(NSOS) : 1;

    logic [1:0]     state;
    logic [CHW-1:0] ch_q;
    logic [SW-1:0]  sec_q;
    logic [2:0]     tap_q;

    // Outputs are registered decodes of the current state and counters, so
    // they trail the FSM by one cycle; this sets the 1+NCH*NSOS*(NTAP+1) latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ch_q       <= '0;
            sec_q      <= '0;
            tap_q      <= '0;
            busy       <= 1'b0;
            ch         <= '0;
            coeff_addr <= '0;
            st_addr    <= '0;
            opsel      <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            wb_en      <= 1'b0;
            dv_out     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            busy       <= (state != S_IDLE);
            mac_en     <= (state == S_MAC);
            mac_clr    <= (state == S_MAC) && (tap_q == OP_X0);
            wb_en      <= (state == S_WB);
            dv_out     <= (state == S_DONE);
            ch         <= ch_q;
            opsel      <= tap_q;
            coeff_addr <= CAW'(int'(sec_q) * NTAP + int'(tap_q));
            st_addr    <= SAW'(int'(ch_q) * NSOS + int'(sec_q));

            if (dv_in && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (dv_in) begin
                        state <= S_MAC;
                        ch_q  <= '0;
                        sec_q <= '0;
                        tap_q <= '0;
                    end
                end
                S_MAC: begin
                    if (tap_q == OP_Y2) begin
                        tap_q <= '0;
                        state <= S_WB;
                    end else begin
                        tap_q <= tap_q + 3'd1;
                    end
                end
                S_WB: begin
                    if (int'(sec_q) < NSOS-1) begin
                        sec_q <= sec_q + SW'(1);
                        state <= S_MAC;
                    end else if (int'(ch_q) < NCH-1) begin
                        sec_q <= '0;
                        ch_q  <= ch_q + CHW'(1);
                        state <= S_MAC;
                    end else begin
                        // Park counters at zero so idle addresses read 0.
                        sec_q <= '0;
                        ch_q  <= '0;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
